// File: rtl/descrambler_sync.sv
// -----------------------------------------------------------------------------
// descrambler_sync
//
// Self-synchronising descrambler for the readout RX path, polynomial
// x^TAP_B + x^TAP_A + 1, processed LSB-first (din[0] is the first bit on the
// line). A registered output stage, a fill phase after reset or bypass exit,
// and a header-based lock FSM are wrapped around the descrambler core. The
// locked output gates the downstream frame decoder.
//
// Optional feature macro: DESCRAMBLER_ERRCNT_EN
//   defined     : err_cnt counts bad headers seen while LOCKED, err_clr clears it
//   not defined : err_cnt is tied to zero, err_clr is ignored
//
// Ports
//   clk        in   1          clock, all logic on the rising edge
//   reset      in   1          synchronous, active-high
//   bypass     in   1          1: dout follows din, descrambler state frozen
//   din        in   WORDWIDTH  scrambled word, bit 0 first on the line
//   din_valid  in   1          din qualifier
//   dout       out  WORDWIDTH  descrambled word (registered)
//   dout_valid out  1          dout qualifier
//   locked     out  1          lock FSM is in LOCKED
//   err_cnt    out  16         bad-header count while LOCKED (saturating)
//   err_clr    in   1          synchronous clear of err_cnt
//   dbg_state  out  2          current lock FSM state (FILL=0, HUNT=1, LOCKED=2)
//
// Handshake: valid-only streaming, no back-pressure. A word is consumed on
// every rising edge where din_valid=1; dout is meaningful only on cycles where
// dout_valid=1 and otherwise holds its last value. dout_valid is din_valid
// delayed by one cycle, except for words suppressed during the fill phase.
// -----------------------------------------------------------------------------
module descrambler_sync #(
  parameter int WORDWIDTH = 40,
  parameter int TAP_A = 39,
  parameter int TAP_B = 58,
  parameter int HDR_W = 2,
  parameter logic [HDR_W-1:0] HDR_VAL = 2'b10,
  parameter int LOCK_CNT = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bypass,
  input  logic [WORDWIDTH-1:0] din,
  input  logic                 din_valid,
  output logic [WORDWIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 locked,
  output logic [15:0]          err_cnt,
  input  logic                 err_clr,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // 9-bit forms of the parameters so every compare below is width-matched.
  localparam logic [8:0] WW9     = 9'(WORDWIDTH);
  localparam logic [8:0] TAPB9   = 9'(TAP_B);
  localparam logic [8:0] LOCK9   = 9'(LOCK_CNT);
  localparam logic [8:0] UNLOCK9 = 9'(UNLOCK_CNT);

  state_t               state;
  logic [TAP_B-1:0]     r;          // last TAP_B line bits, r[0] most recent
  logic [TAP_B-1:0]     r_next;
  logic [WORDWIDTH-1:0] desc;
  logic [7:0]           fill_cnt;
  logic [8:0]           fill_sum;
  logic [7:0]           good_cnt;
  logic [7:0]           bad_cnt;
  logic [8:0]           good_inc;
  logic [8:0]           bad_inc;
  logic                 hdr_good;

  assign dbg_state = state;

  // Bit-serial descrambler unrolled across the word. Each received bit is
  // shifted into the chain after it has been used, so bit i sees the bits
  // TAP_A and TAP_B positions earlier on the line, even across word borders.
  always_comb begin
    logic [TAP_B-1:0] c;
    c    = r;
    desc = '0;
    for (int i = 0; i < WORDWIDTH; i++) begin
      desc[i] = din[i] ^ c[TAP_A-1] ^ c[TAP_B-1];
      c       = {c[TAP_B-2:0], din[i]};
    end
    r_next = c;
  end

  assign hdr_good = (desc[WORDWIDTH-1 -: HDR_W] == HDR_VAL);
  assign fill_sum = {1'b0, fill_cnt} + WW9;
  assign good_inc = {1'b0, good_cnt} + 9'd1;
  assign bad_inc  = {1'b0, bad_cnt} + 9'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r          <= '0;
      fill_cnt   <= '0;
      state      <= ST_FILL;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
    end else if (bypass) begin
      // Raw pass-through. The descrambler history is frozen so a stream that
      // was also paused upstream resumes aligned, but the fill phase is
      // restarted because that cannot be assumed in general.
      dout_valid <= din_valid;
      if (din_valid) begin
        dout <= din;
      end
      state    <= ST_FILL;
      fill_cnt <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      locked   <= 1'b0;
    end else if (!din_valid) begin
      dout_valid <= 1'b0;
    end else begin
      r <= r_next;
      case (state)
        ST_FILL: begin
          // Output is unreliable until TAP_B line bits have been absorbed;
          // the word that completes the history is still suppressed.
          dout_valid <= 1'b0;
          fill_cnt   <= fill_sum[8] ? 8'hFF : fill_sum[7:0];
          if (fill_sum >= TAPB9) begin
            state    <= ST_HUNT;
            good_cnt <= '0;
          end
        end
        ST_HUNT: begin
          dout_valid <= 1'b1;
          dout       <= desc;
          if (hdr_good) begin
            if (good_inc >= LOCK9) begin
              state    <= ST_LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else begin
              good_cnt <= good_inc[7:0];
            end
          end else begin
            good_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          dout_valid <= 1'b1;
          dout       <= desc;
          if (!hdr_good) begin
            if (bad_inc >= UNLOCK9) begin
              state    <= ST_HUNT;
              locked   <= 1'b0;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else begin
              bad_cnt <= bad_inc[7:0];
            end
          end else begin
            bad_cnt <= '0;
          end
        end
        default: begin
          state  <= ST_FILL;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef DESCRAMBLER_ERRCNT_EN
  // Counts bad headers of words consumed while LOCKED, including the word
  // that causes the unlock. A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (!bypass && din_valid && (state == ST_LOCKED) && !hdr_good &&
                 (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = 16'h0000;
`endif

endmodule
